// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Optional feature macro used by this slice: UART_TX_PARITY_EN (even parity bit).
package uart_pkg;

  // Transmit FSM states. PARITY only becomes reachable when the parity macro is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// The read port is combinational from the storage array so the FSM can load the head
// entry on the same edge it pops it; the array is small enough to sit in distributed RAM.
module uart_tx_fifo #(
  parameter int depth = 4,
  parameter int width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       wr_data,
  output logic [width-1:0]       rd_data,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == COUNT_FULL);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];

  // A push while full is discarded, even when a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage write; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because depth is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: FIFO-buffered valid/ready input, 8N1 serial output.
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 4,
  parameter int fifo_depth     = 4,
  parameter int stop_bits      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [UART_DATA_BITS-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        out_ready,
  output logic                        out_serial,
  output logic                        out_busy,
  output logic [$clog2(fifo_depth):0] out_count
);

  localparam int STOP_CYCLES = stop_bits * clocks_per_bit;
  localparam int CW          = $clog2(STOP_CYCLES);
  localparam int IW          = $clog2(UART_DATA_BITS);

  // The counter is shared by every bit period; stop is the longest, so it sets the width.
  localparam logic [CW-1:0] BIT_LAST  = CW'(clocks_per_bit - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);

  tx_state_t                 state_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [CW-1:0]             cycle_count_reg;
  logic [IW-1:0]             bit_index_reg;
  logic                      serial_reg;
  logic                      busy_reg;
`ifdef UART_TX_PARITY_EN
  logic                      parity_reg;
`endif

  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic                      bit_last;

  uart_tx_fifo #(
    .depth (fifo_depth),
    .width (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .pop     (fifo_pop),
    .wr_data (in_data),
    .rd_data (fifo_rd_data),
    .count   (out_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_ready  = !fifo_full;
  assign out_serial = serial_reg;
  assign out_busy   = busy_reg;
  assign bit_last   = (cycle_count_reg == BIT_LAST);

  // Pop when idle, or on the final stop cycle so the next start bit follows with no gap.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state_reg == IDLE) begin
        fifo_pop = 1'b1;
      end else if (state_reg == STOP && cycle_count_reg == STOP_LAST) begin
        fifo_pop = 1'b1;
      end
    end
  end

  // Frame sequencer: the serial level is registered and set on the edge that enters each bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      cycle_count_reg <= '0;
      bit_index_reg   <= '0;
      serial_reg      <= UART_IDLE_LEVEL;
      busy_reg        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          serial_reg      <= UART_IDLE_LEVEL;
          busy_reg        <= 1'b0;
          cycle_count_reg <= '0;
          if (fifo_pop) begin
            shift_reg  <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            parity_reg <= even_parity(fifo_rd_data);
`endif
            state_reg  <= START;
            serial_reg <= ~UART_IDLE_LEVEL;
            busy_reg   <= 1'b1;
          end
        end

        START: begin
          if (bit_last) begin
            cycle_count_reg <= '0;
            bit_index_reg   <= '0;
            state_reg       <= DATA;
            serial_reg      <= shift_reg[0];
          end else begin
            cycle_count_reg <= cycle_count_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_last) begin
            cycle_count_reg <= '0;
            shift_reg       <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
            if (bit_index_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_reg  <= PARITY;
              serial_reg <= parity_reg;
`else
              state_reg  <= STOP;
              serial_reg <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_index_reg <= bit_index_reg + 1'b1;
              // Next data bit is the one that becomes shift_reg[0] after this shift.
              serial_reg    <= shift_reg[1];
            end
          end else begin
            cycle_count_reg <= cycle_count_reg + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_last) begin
            cycle_count_reg <= '0;
            state_reg       <= STOP;
            serial_reg      <= UART_IDLE_LEVEL;
          end else begin
            cycle_count_reg <= cycle_count_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cycle_count_reg == STOP_LAST) begin
            cycle_count_reg <= '0;
            if (fifo_pop) begin
              shift_reg  <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
              parity_reg <= even_parity(fifo_rd_data);
`endif
              state_reg  <= START;
              serial_reg <= ~UART_IDLE_LEVEL;
            end else begin
              state_reg  <= IDLE;
              serial_reg <= UART_IDLE_LEVEL;
              busy_reg   <= 1'b0;
            end
          end else begin
            cycle_count_reg <= cycle_count_reg + 1'b1;
          end
        end

        default: begin
          state_reg  <= IDLE;
          serial_reg <= UART_IDLE_LEVEL;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed steps, a serial-line decoder and a byte scoreboard.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT  = 1;
`else
  localparam int PBIT  = 0;
`endif
  localparam int FRAME_CYC = (1 + 8 + PBIT + STOPB) * CPB;

  logic                   clk;
  logic                   reset;
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   out_ready;
  logic                   out_serial;
  logic                   out_busy;
  logic [$clog2(DEPTH):0] out_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_start_q[$];

  uart_tx #(
    .clocks_per_bit (CPB),
    .fifo_depth     (DEPTH),
    .stop_bits      (STOPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .out_serial (out_serial),
    .out_busy   (out_busy),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Line decoder: samples each bit at its centre and collects received bytes.
  int         mon_cnt    = 0;
  bit         mon_active = 1'b0;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (out_serial === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        rx_start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= CPB && mon_cnt < 9 * CPB && (mon_cnt % CPB) == CPB / 2)
        mon_byte[mon_cnt / CPB - 1] = out_serial;
      if (mon_cnt == 9 * CPB - CPB / 2)
        rx_q.push_back(mon_byte);
      if (mon_cnt == FRAME_CYC - 1)
        mon_active = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Push one byte, then check the complete line waveform and busy window of its frame.
  task automatic send_and_check_frame(input logic [7:0] b);
    logic expl;
    @(negedge clk);
    chk("ready_before_push", {31'd0, out_ready}, 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
    chk("line_idle_after_push_edge", {31'd0, out_serial}, 32'd1);
    chk("busy_low_after_push_edge", {31'd0, out_busy}, 32'd0);
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      if (k < CPB)            expl = 1'b0;
      else if (k < 9 * CPB)   expl = b[(k - CPB) / CPB];
      else if (k < (9 + PBIT) * CPB) expl = ^b;
      else                    expl = 1'b1;
      chk($sformatf("line_%02h_cycle%0d", b, k), {31'd0, out_serial}, {31'd0, expl});
      chk($sformatf("busy_%02h_cycle%0d", b, k), {31'd0, out_busy}, 32'd1);
    end
    @(negedge clk);
    chk("busy_drops_after_frame", {31'd0, out_busy}, 32'd0);
    chk("line_idle_after_frame", {31'd0, out_serial}, 32'd1);
  endtask

  // Pop every expected byte against the decoder output, with a bounded wait for each.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      int t = 0;
      while (rx_q.size() == 0 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (rx_q.size() == 0) begin
        chk({tag, "_timeout"}, 32'd0, 32'd1);
        exp_q.delete();
      end else begin
        logic [7:0] got;
        logic [7:0] want;
        got  = rx_q.pop_front();
        want = exp_q.pop_front();
        $display("rx %s: byte %02h (expected %02h)", tag, got, want);
        chk(tag, {24'd0, got}, {24'd0, want});
      end
    end
  endtask

  initial begin
    int lows;
    int exp_cnt[8];
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_serial", {31'd0, out_serial}, 32'd1);
    chk("reset_busy", {31'd0, out_busy}, 32'd0);
    chk("reset_count", {29'd0, out_count}, 32'd0);
    chk("reset_ready", {31'd0, out_ready}, 32'd1);
    reset = 1'b0;

    // Idle line for 100 cycles with nothing offered.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("idle_serial", {31'd0, out_serial}, 32'd1);
      chk("idle_ready", {31'd0, out_ready}, 32'd1);
      chk("idle_count", {29'd0, out_count}, 32'd0);
    end

    // Single byte, exact waveform.
    send_and_check_frame(8'h55);
    drain("single_55");
`ifdef UART_TX_PARITY_EN
    send_and_check_frame(8'h07);
    drain("parity_07");
    send_and_check_frame(8'h03);
    drain("parity_03");
`endif
    repeat (10) @(negedge clk);

    // Back-to-back frames from consecutive pushes.
    rx_start_q.delete();
    foreach (exp_cnt[i]) exp_cnt[i] = 0;
    begin
      logic [7:0] seq[3];
      seq = '{8'h00, 8'hFF, 8'hA5};
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("loopback_ready", {31'd0, out_ready}, 32'd1);
        in_data  = seq[k];
        in_valid = 1'b1;
        exp_q.push_back(seq[k]);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    drain("loopback");
    repeat (FRAME_CYC) @(negedge clk);
    chk("loopback_frames", rx_start_q.size(), 32'd3);
    if (rx_start_q.size() >= 3) begin
      chk("gap_frame0_1", rx_start_q[1] - rx_start_q[0], FRAME_CYC);
      chk("gap_frame1_2", rx_start_q[2] - rx_start_q[1], FRAME_CYC);
    end
    repeat (10) @(negedge clk);

    // Backpressure: offer 0x01..0x08 on consecutive cycles; only 0x01..0x05 fit.
    exp_cnt = '{0, 1, 1, 2, 3, 4, 4, 4};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("bp_count_step%0d", k), {29'd0, out_count}, exp_cnt[k]);
      chk($sformatf("bp_ready_step%0d", k), {31'd0, out_ready}, (k < 5) ? 32'd1 : 32'd0);
      in_data  = 8'(k + 1);
      in_valid = 1'b1;
      if (k < 5) exp_q.push_back(8'(k + 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("backpressure");
    repeat (100) @(negedge clk);
    chk("bp_no_extra_bytes", rx_q.size(), 32'd0);

    // Reset mid-frame with two bytes still queued.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_data  = 8'hC0 + 8'(k);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_busy", {31'd0, out_busy}, 32'd1);
    chk("pre_reset_count", {29'd0, out_count}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_serial", {31'd0, out_serial}, 32'd1);
    chk("midreset_busy", {31'd0, out_busy}, 32'd0);
    chk("midreset_count", {29'd0, out_count}, 32'd0);
    chk("midreset_ready", {31'd0, out_ready}, 32'd1);
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_serial !== 1'b1) lows++;
    end
    chk("no_start_after_reset", lows, 32'd0);
    chk("no_bytes_after_reset", rx_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
